md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu/mthi/mtlo and holds the architectural HI/LO registers. Its busy and start outputs feed the hazard unit, which stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while the unit is occupied. The M-stage result mux reads hi/lo for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (range 1..15)
DIV_CYCLES, 10, busy duration in cycles for div/divu (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
start  input  1  one-cycle pulse: E-stage instruction is an md op (already forwarded operands valid)
md_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
busy  output  1  unit computing; hazard unit stalls md-type D instructions while busy|start
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, busy=0, hi=0, lo=0, counter=0, temp result=0. Overrides everything, including an in-flight operation.
- States: IDLE, RUN.
- IDLE, start=1, md_op in {MULT,MULTU,DIV,DIVU}:
  - At that edge, the full 64-bit result is computed combinationally from rs_val/rt_val and latched into temp_hi/temp_lo.
  - counter loads N (MULT_CYCLES or DIV_CYCLES); go to RUN.
- RUN:
  - busy=1 (registered output); counter decrements each edge.
  - On the edge where counter==1: hi/lo load temp values, busy drops, return to IDLE.
  - Timing: start sampled at edge T. busy is high for exactly N cycles (T+1..T+N). New hi/lo are visible from cycle T+N+1, in the same cycle busy reads 0.
- IDLE, start=1, MTHI/MTLO: hi (or lo) loads rs_val at that edge. busy never asserts; single-cycle.
- start=1 with md_op NONE or 7: no effect.
- start=1 while busy=1:
  - Illegal; the hazard unit guarantees it cannot occur.
  - Unit ignores it; operands and temp result are not disturbed.
  - Bench asserts on it.
- MULT: signed 32x32 -> 64, hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: signed, quotient truncates toward zero (lo), remainder takes sign of dividend (hi).
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divisor==0 (DIV or DIVU): busy still asserts for DIV_CYCLES; hi/lo retain prior values.
- hi/lo change only at RUN completion, MTHI/MTLO, or reset; otherwise they are stable.

Decomposition:
- Shared package (mips_defs): md_op encodings MD_NONE..MD_MTLO, default MULT_CYCLES/DIV_CYCLES constants, state encoding.
- The hazard unit imports the same package to decode md-type D instructions.
- Sub-module md_div_core: combinational signed/unsigned quotient/remainder with the divide-by-zero flag. Isolates the sign-fixup logic so it can be verified standalone.
- Multiply stays inline.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high cycles T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9(-7) rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1.
- Preload hi=0xAAAA0000, lo=0x5555 via MTHI/MTLO; then DIV rt=0 -> busy 10 cycles, hi/lo unchanged. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next cycle; busy stays 0 throughout.
- Start DIV, drive reset=0 at cycle T+3 -> next cycle busy=0, hi=lo=0. Then a new MULT 3*4 completes normally with lo=12, hi=0. Also a start pulse during busy is ignored: result equals the first op's.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: md_op encodings, default latencies and FSM state encoding for the multiply/divide unit.
package md_unit_pkg;
  typedef logic [2:0] md_op_t;
  localparam md_op_t MD_NONE  = 3'd0;
  localparam md_op_t MD_MULT  = 3'd1;
  localparam md_op_t MD_MULTU = 3'd2;
  localparam md_op_t MD_DIV   = 3'd3;
  localparam md_op_t MD_DIVU  = 3'd4;
  localparam md_op_t MD_MTHI  = 3'd5;
  localparam md_op_t MD_MTLO  = 3'd6;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request and HI/LO/busy response bundle of the multiply/divide unit.
interface md_unit_if;
  import md_unit_pkg::*;
  logic        start;
  md_op_t      md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, md_op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/md_unit_div_core.sv
// md_div_core: combinational signed/unsigned 32-bit divide with sign fixup and divide-by-zero flag.
module md_div_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sgn_i,
  output logic [31:0] q_o,
  output logic [31:0] r_o,
  output logic        dz_o
);
  logic        na, nb;
  logic [31:0] ua, ub, uq, ur;
  always_comb begin
    na   = sgn_i & a_i[31];
    nb   = sgn_i & b_i[31];
    ua   = na ? -a_i : a_i;
    ub   = nb ? -b_i : b_i;
    dz_o = b_i == 32'd0;
    uq   = dz_o ? 32'd0 : ua / ub;
    ur   = dz_o ? 32'd0 : ua % ub;
    // quotient truncates toward zero, remainder follows the dividend
    q_o  = (na ^ nb) ? -uq : uq;
    r_o  = na ? -ur : ur;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS E-stage multiply/divide unit holding HI/LO with fixed-latency busy window.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   reset,
  md_unit_if.slave md
);
  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d, hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;
  logic [63:0] ea, eb, prod;
  logic [31:0] dq, dr;
  logic        dz, sm;

  md_div_core u_div (
    .a_i  (md.rs_val),
    .b_i  (md.rt_val),
    .sgn_i(md.md_op == MD_DIV),
    .q_o  (dq),
    .r_o  (dr),
    .dz_o (dz)
  );

  // sign-extending both operands lets one 64-bit multiplier serve mult and multu
  assign sm   = md.md_op == MD_MULT;
  assign ea   = {{32{sm & md.rs_val[31]}}, md.rs_val};
  assign eb   = {{32{sm & md.rt_val[31]}}, md.rt_val};
  assign prod = ea * eb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        hi_d    = dz_q ? hi_q : thi_q;
        lo_d    = dz_q ? lo_q : tlo_q;
      end
    end else if (md.start) begin
      case (md.md_op)
        MD_MULT, MD_MULTU: begin
          state_d        = S_RUN;
          cnt_d          = 4'(MULT_CYCLES);
          {thi_d, tlo_d} = prod;
          dz_d           = 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          state_d = S_RUN;
          cnt_d   = 4'(DIV_CYCLES);
          thi_d   = dr;
          tlo_d   = dq;
          dz_d    = dz;
        end
        MD_MTHI: hi_d = md.rs_val;
        MD_MTLO: lo_d = md.rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = state_q == S_RUN;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: random and directed stimulus for md_unit checked against a cycle-stamped arithmetic model.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  md_unit_if bus ();
  md_unit dut (.clk(clk), .reset(reset), .md(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  longint cyc = 0, done_at = -1;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic p_dz = 1'b0;
  logic allow_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  // model: an accepted op at edge s finishes at edge s+N; the unit is free only after that edge
  always @(posedge clk) begin
    longint a, b, q, r;
    longint unsigned p;
    cyc++;
    if (!reset) begin
      m_hi = 0; m_lo = 0; done_at = -1;
    end else begin
      if (cyc == done_at && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
      if (bus.start) begin
        if (cyc <= done_at) begin
          if (!allow_ill) chk("start_while_busy", 32'd1, 32'd0);
        end else begin
          case (bus.md_op)
            3'd1: begin
              a = $signed(bus.rs_val); b = $signed(bus.rt_val); q = a * b;
              {p_hi, p_lo} = q; p_dz = 0; done_at = cyc + 5;
            end
            3'd2: begin
              p = {32'b0, bus.rs_val}; p = p * {32'b0, bus.rt_val};
              {p_hi, p_lo} = p; p_dz = 0; done_at = cyc + 5;
            end
            3'd3: begin
              p_dz = bus.rt_val == 0; done_at = cyc + 10;
              if (!p_dz) begin
                a = $signed(bus.rs_val); b = $signed(bus.rt_val); q = a / b; r = a % b;
                p_lo = q[31:0]; p_hi = r[31:0];
              end
            end
            3'd4: begin
              p_dz = bus.rt_val == 0; done_at = cyc + 10;
              if (!p_dz) begin p_lo = bus.rs_val / bus.rt_val; p_hi = bus.rs_val % bus.rt_val; end
            end
            3'd5: m_hi = bus.rs_val;
            3'd6: m_lo = bus.rs_val;
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("busy", 32'(bus.busy), 32'(cyc < done_at));
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  end

  task automatic wait_idle(output int nb);
    nb = 0;
    while (bus.busy && nb < 40) begin nb++; @(negedge clk); end
    if (nb >= 40) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
    bus.start = 1; bus.md_op = op; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 0;
    wait_idle(nb);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    bus.start = 0; bus.md_op = 0; bus.rs_val = 0; bus.rt_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1;
    @(negedge clk);
    do_op(3'd1, 32'hFFFFFFFF, 32'h2, nb);
    chk("mult_cycles", nb, 5); chk("mult_hi", bus.hi, 32'hFFFFFFFF); chk("mult_lo", bus.lo, 32'hFFFFFFFE);
    do_op(3'd2, 32'hFFFFFFFF, 32'h2, nb);
    chk("multu_cycles", nb, 5); chk("multu_hi", bus.hi, 32'h1); chk("multu_lo", bus.lo, 32'hFFFFFFFE);
    do_op(3'd3, 32'hFFFFFFF9, 32'h2, nb);
    chk("div_cycles", nb, 10); chk("div_hi", bus.hi, 32'hFFFFFFFF); chk("div_lo", bus.lo, 32'hFFFFFFFD);
    do_op(3'd4, 32'h7, 32'h2, nb);
    chk("divu_hi", bus.hi, 32'h1); chk("divu_lo", bus.lo, 32'h3);
    do_op(3'd5, 32'hAAAA0000, 32'h0, nb);
    do_op(3'd6, 32'h00005555, 32'h0, nb);
    do_op(3'd3, 32'h1234, 32'h0, nb);
    chk("div0_cycles", nb, 10); chk("div0_hi", bus.hi, 32'hAAAA0000); chk("div0_lo", bus.lo, 32'h5555);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, nb);
    chk("ovf_hi", bus.hi, 32'h0); chk("ovf_lo", bus.lo, 32'h80000000);
    do_op(3'd5, 32'h12345678, 32'h0, nb);
    chk("mthi_cycles", nb, 0); chk("mthi_hi", bus.hi, 32'h12345678);
    do_op(3'd7, 32'hDEADBEEF, 32'h1, nb);
    do_op(3'd0, 32'hDEADBEEF, 32'h1, nb);
    chk("nop_hi", bus.hi, 32'h12345678); chk("nop_lo", bus.lo, 32'h80000000);
    bus.start = 1; bus.md_op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0); chk("abort_hi", bus.hi, 32'h0); chk("abort_lo", bus.lo, 32'h0);
    reset = 1;
    do_op(3'd1, 32'd3, 32'd4, nb);
    chk("post_rst_hi", bus.hi, 32'h0); chk("post_rst_lo", bus.lo, 32'd12);
    bus.start = 1; bus.md_op = 3'd1; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
    @(negedge clk);
    allow_ill = 1; bus.md_op = 3'd4; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 0; allow_ill = 0;
    wait_idle(nb);
    chk("ill_hi", bus.hi, 32'h0); chk("ill_lo", bus.lo, 32'd30);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 0; @(negedge clk); reset = 1;
      end
      do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
